// File: rtl/apb_led_pkg.sv
// Shared types and register-map constants for the APB LED bank.
// Optional PWM support is selected with APB_LED_BANK_PWM_EN.
package apb_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } led_mode_t;

  // Byte offsets of the two registers inside one 8-byte channel window
  localparam logic [2:0] CTRL_OFS = 3'd0;
  localparam logic [2:0] DUTY_OFS = 3'd4;
  localparam int         CH_STRIDE_LOG2 = 3;

  localparam int MODE_MSB = 31;
  localparam int MODE_LSB = 30;

endpackage

// File: rtl/apb_led_chan.sv
// One LED channel: free-running period counter, blink phase and LED drive.
// PWM compare exists only when APB_LED_BANK_PWM_EN is defined.
module apb_led_chan
  import apb_led_pkg::*;
#(
  parameter int CNT_W = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  led_mode_t        mode,
  input  logic [CNT_W-1:0] period,
`ifdef APB_LED_BANK_PWM_EN
  input  logic [CNT_W-1:0] duty,
`endif
  input  logic             ctrl_wr,
  output logic             led
);

  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;
  logic             pwm_s;

  // Counter and phase; a CTRL write restarts the channel ahead of the wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (ctrl_wr) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == period) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
      phase_r <= phase_r;
    end
  end

  // PWM level; without PWM support mode 11 falls back to blinking
  always_comb begin
    pwm_s = 1'b0;
`ifdef APB_LED_BANK_PWM_EN
    pwm_s = (cnt_r < duty);
`else
    pwm_s = phase_r;
`endif
  end

  // LED drive selected by mode
  always_comb begin
    led = 1'b0;
    case (mode)
      MODE_OFF:   led = 1'b0;
      MODE_ON:    led = 1'b1;
      MODE_BLINK: led = phase_r;
      MODE_PWM:   led = pwm_s;
      default:    led = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_led_bank.sv
// APB-programmable bank of NUM_CH LED channels (OFF/ON/BLINK/PWM).
// Define APB_LED_BANK_PWM_EN to enable the DUTY registers and PWM mode.
module apb_led_bank
  import apb_led_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 30,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] LED
);

  led_mode_t        mode_r   [NUM_CH];
  logic [CNT_W-1:0] period_r [NUM_CH];
`ifdef APB_LED_BANK_PWM_EN
  logic [CNT_W-1:0] duty_r   [NUM_CH];
  logic [NUM_CH-1:0] duty_wr_s;
`endif
  logic [NUM_CH-1:0] ctrl_wr_s;
  logic              wr_s;
  logic [31:0]       ch_num_s;
  logic [2:0]        ofs_s;
  logic              is_ctrl_s;
  logic [31:0]       word_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  assign wr_s      = PSEL & PENABLE & PWRITE;
  assign ch_num_s  = 32'(PADDR[ADDR_W-1:CH_STRIDE_LOG2]);
  assign ofs_s     = {PADDR[2], 2'b00};
  assign is_ctrl_s = (ofs_s == CTRL_OFS);
  assign unused_s  = ^{PADDR[1:0], PWDATA};

  // Per-channel write strobes; addresses past the last channel match nothing
  always_comb begin
    ctrl_wr_s = '0;
`ifdef APB_LED_BANK_PWM_EN
    duty_wr_s = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_wr_s[i] = wr_s && (ch_num_s == 32'(i)) && is_ctrl_s;
`ifdef APB_LED_BANK_PWM_EN
      duty_wr_s[i] = wr_s && (ch_num_s == 32'(i)) && (ofs_s == DUTY_OFS);
`endif
    end
  end

  // Register file; reset wins over a write in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_r[i]   <= MODE_OFF;
        period_r[i] <= '0;
`ifdef APB_LED_BANK_PWM_EN
        duty_r[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ctrl_wr_s[i]) begin
          mode_r[i]   <= led_mode_t'(PWDATA[MODE_MSB:MODE_LSB]);
          period_r[i] <= PWDATA[CNT_W-1:0];
        end else begin
          mode_r[i]   <= mode_r[i];
          period_r[i] <= period_r[i];
        end
`ifdef APB_LED_BANK_PWM_EN
        if (duty_wr_s[i]) begin
          duty_r[i] <= PWDATA[CNT_W-1:0];
        end else begin
          duty_r[i] <= duty_r[i];
        end
`endif
      end
    end
  end

  // Readback mux: OR of the one matching channel word, zero when unmapped
  always_comb begin
    rdata_s = 32'd0;
    word_s  = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      word_s = 32'd0;
      if (is_ctrl_s) begin
        word_s[CNT_W-1:0]         = period_r[i];
        word_s[MODE_MSB:MODE_LSB] = mode_r[i];
      end else begin
`ifdef APB_LED_BANK_PWM_EN
        word_s[CNT_W-1:0] = duty_r[i];
`else
        word_s = 32'd0;
`endif
      end
      rdata_s = rdata_s | ((ch_num_s == 32'(i)) ? word_s : 32'd0);
    end
  end

  assign PRDATA  = PSEL ? rdata_s : 32'd0;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    apb_led_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode    (mode_r[g]),
      .period  (period_r[g]),
`ifdef APB_LED_BANK_PWM_EN
      .duty    (duty_r[g]),
`endif
      .ctrl_wr (ctrl_wr_s[g]),
      .led     (LED[g])
    );
  end

endmodule

// File: tb/tb_apb_led_bank.sv
// Scoreboard bench for apb_led_bank: a time-since-restart reference model
// predicts LED and PRDATA each cycle; a monitor compares on the falling edge.
module tb_apb_led_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 30;
  localparam int ADDR_W = 8;
  localparam logic [31:0] FMASK     = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] CTRL_MASK = 32'hC000_0000 | FMASK;

  logic              clk = 1'b0;
  logic              rst_n, psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata, prdata;
  logic              pready, pslverr;
  logic [NUM_CH-1:0] led;

  typedef struct packed {
    logic [NUM_CH-1:0] led;
    logic [31:0]       rd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_ctrl [NUM_CH];
  logic [31:0] m_duty [NUM_CH];
  longint      m_t    [NUM_CH];

  apb_led_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr), .LED(led)
  );

  always #5 clk = ~clk;

  // LED level after t cycles since the last restart (reset or CTRL write)
  function automatic logic model_led(int i);
    longint p   = longint'(m_ctrl[i] & FMASK) + 1;
    longint cnt = m_t[i] % p;
    logic   ph  = ((m_t[i] / p) % 2) == 1;
    case (m_ctrl[i][31:30])
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return ph;
`ifdef APB_LED_BANK_PWM_EN
      default: return cnt < longint'(m_duty[i]);
`else
      default: return ph;
`endif
    endcase
  endfunction

  function automatic logic [31:0] model_read(logic [ADDR_W-1:0] a);
    int ch = int'(a >> 3);
    if (ch >= NUM_CH) return 32'd0;
    if (a[2] == 1'b0) return m_ctrl[ch];
`ifdef APB_LED_BANK_PWM_EN
    return m_duty[ch];
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_ctrl[i] = 32'd0;
      m_duty[i] = 32'd0;
      m_t[i]    = 0;
    end
  endtask

  // One clock: drive inputs, push the expected response, advance the model
  task automatic step(input logic r, input logic s, input logic e, input logic w,
                      input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_t ex;
    int   ch;
    rst_n = r; psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    for (int i = 0; i < NUM_CH; i++) ex.led[i] = model_led(i);
    ex.rd = s ? model_read(a) : 32'd0;
    q.push_back(ex);
    @(posedge clk);
    if (!r) begin
      model_clear();
    end else begin
      for (int i = 0; i < NUM_CH; i++) m_t[i] = m_t[i] + 1;
      ch = int'(a >> 3);
      if (s && e && w && ch < NUM_CH) begin
        if (a[2] == 1'b0) begin
          m_ctrl[ch] = d & CTRL_MASK;
          m_t[ch]    = 0;
        end else begin
`ifdef APB_LED_BANK_PWM_EN
          m_duty[ch] = d & FMASK;
`endif
        end
      end
    end
    #1;
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b1, a, d);
    step(1'b1, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] a);
    step(1'b1, 1'b1, 1'b0, 1'b0, a, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  // Monitor: pops one expectation per cycle and compares outputs
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        ex = q.pop_front();
        checks++;
        if (led !== ex.led) begin
          errors++;
          $display("FAIL led t=%0t: got %b want %b", $time, led, ex.led);
        end
        checks++;
        if (prdata !== ex.rd) begin
          errors++;
          $display("FAIL prdata t=%0t addr=%h: got %h want %h", $time, paddr, prdata, ex.rd);
        end
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b0) begin
          errors++;
          $display("FAIL handshake t=%0t: got ready=%b err=%b want 1 0", $time, pready, pslverr);
        end
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = 32'd0;
    @(posedge clk);
    model_clear();
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);

    for (int k = 0; k < 2 * NUM_CH + 2; k++) apb_read(8'(4 * k));

    apb_write(8'h00, 32'h8000_0003);
    idle(12);
    apb_write(8'h00, 32'h8000_0003);
    idle(1);
    apb_write(8'h00, 32'h8000_0003);
    idle(10);

    apb_write(8'(8 * NUM_CH), 32'hFFFF_FFFF);
    apb_read(8'(8 * NUM_CH));

    apb_write(8'h08, 32'hC000_0009);
    apb_write(8'h0C, 32'd3);
    idle(22);
    apb_write(8'h0C, 32'd0);
    idle(12);
    apb_write(8'h0C, 32'd10);
    idle(12);
    apb_read(8'h0C);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h08, 32'h4000_0000);
    idle(3);

    apb_write(8'h10, 32'hC000_0001);
    idle(9);
    apb_write(8'h14, 32'h0000_00FF);
    apb_read(8'h14);
    apb_write(8'h18, 32'h7FFF_FFF2);
    apb_read(8'h18);
    idle(6);

    for (int n = 0; n < 3000; n++) begin
      a = 8'($urandom_range(0, 8 * NUM_CH + 15));
      if ($urandom_range(0, 7) == 0) d = $urandom;
      else if (a[2] == 1'b0) d = {2'($urandom_range(0, 3)), 30'($urandom_range(0, 9))};
      else d = 32'($urandom_range(0, 12));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
           1'($urandom), 1'($urandom), a, d);
    end

    idle(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_led_bank.md
APB_LED_BANK -- requirements
Module: apb_led_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of LED channels (1..16).
REQ-002 Parameter CNT_W, default 30, width of the period and duty fields (1..30).
REQ-003 Parameter ADDR_W, default 8, number of PADDR bits decoded (at least log2(NUM_CH)+3).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port PSEL  input  1  APB select.
REQ-007 Port PENABLE  input  1  APB access phase.
REQ-008 Port PWRITE  input  1  APB write (1) or read (0).
REQ-009 Port PADDR  input  ADDR_W  byte address, word aligned; PADDR[1:0] ignored.
REQ-010 Port PWDATA  input  32  write data.
REQ-011 Port PRDATA  output  32  read data.
REQ-012 Port PREADY  output  1  tied 1; no wait states.
REQ-013 Port PSLVERR  output  1  tied 0.
REQ-014 Port LED  output  NUM_CH  per-channel LED drive, 1 = lit.

Function
REQ-015 Per channel i: CTRL register at 8*i, {MODE[31:30], zeros, PERIOD[CNT_W-1:0]}; DUTY register at 8*i+4, {zeros, DUTY[CNT_W-1:0]}.
REQ-016 Write strobe = PSEL & PENABLE & PWRITE; register takes PWDATA at that edge; bits outside defined fields are dropped and read back 0.
REQ-017 Reads are combinational: PRDATA = addressed register while PSEL is high, else 0; unmapped addresses read 0; writes to unmapped addresses are ignored.
REQ-018 MODE 00 OFF: LED[i]=0; MODE 01 ON: LED[i]=1; MODE 10 BLINK; MODE 11 PWM.
REQ-019 Each channel has a CNT_W-bit counter: if CNT==PERIOD then CNT<=0, else CNT<=CNT+1; it runs in every mode.
REQ-020 BLINK: phase bit toggles on each cycle where CNT==PERIOD; LED[i]=phase; half-period = PERIOD+1 cycles.
REQ-021 PWM: LED[i] = (CNT < DUTY); DUTY=0 gives always off; DUTY>PERIOD gives always on; PERIOD=0 gives LED = (DUTY!=0).
REQ-022 A write to CTRL[i] clears CNT[i] to 0 and phase[i] to 0 at the same edge; that write has priority over the wrap.
REQ-023 A write to DUTY[i] does not disturb CNT[i] or phase[i]; the new duty applies from the next cycle.
REQ-024 LED is combinational from registered state: a CTRL/DUTY write at edge T is visible on LED after edge T.
REQ-025 Channels are fully independent; a write to one channel leaves the others unchanged.

Reset
REQ-026 When rst_n=0 at a clk edge, all CTRL, DUTY, CNT and phase bits are cleared; LED=0 and PRDATA=0 follow; an APB write in the same cycle is discarded.
REQ-027 Reset applied mid-blink or mid-PWM takes effect at that edge, with no partial update.

Configuration
REQ-028 Macro APB_LED_BANK_PWM_EN defined: MODE 11 is PWM and the DUTY registers exist.
REQ-029 Macro undefined: there is no DUTY storage; DUTY addresses read 0 and ignore writes; MODE 11 behaves as BLINK.

Structure
REQ-030 Package apb_led_pkg holds the led_mode_t enum (OFF, ON, BLINK, PWM), the CTRL/DUTY offset constants and the MODE field bit positions.
REQ-031 Sub-module apb_led_chan holds one channel's counter, phase and LED output logic; it is instantiated NUM_CH times by generate.
REQ-032 APB decode and readback mux stay in apb_led_bank.

Verification
REQ-033 Reset then read all registers -> PRDATA=0 everywhere, LED=0.
REQ-034 Write CTRL0=0x8000_0003 (BLINK, PERIOD 3) -> LED[0] toggles every 4 cycles, first toggle 4 cycles after the write edge; other LEDs stay 0.
REQ-035 PWM_EN: CTRL1=0xC000_0009, DUTY1=3 -> LED[1] high 3 of every 10 cycles; DUTY1=0 -> constant 0; DUTY1=10 -> constant 1.
REQ-036 Rewrite CTRL0 while BLINK counter is at 2 -> CNT restarts at 0, LED[0]=0 next cycle, next toggle 4 cycles later.
REQ-037 Write to address 8*NUM_CH and read it back -> 0, no channel changes; assert rst_n=0 for one cycle mid-PWM -> all outputs 0 at that edge.
REQ-038 Without PWM_EN: CTRL2=0xC000_0001 -> LED[2] blinks with a half-period of 2 cycles; DUTY2 reads 0 after writing 0xFF.
